stream_out_buffer: RTL and testbench

- Console-to-memory staging buffer for the RAM test path. The console loads a 256 x 32-bit pattern.
- On START, the block streams the pattern out as 16-bit halfwords over a valid/ready handshake toward the SDRAM write path.
- Halfword order: for halfword index i, word i/2 is used; i%2=0 selects bits 15:0, i%2=1 selects bits 31:16.

---
 rtl/sob_pkg.sv | 16 +
 rtl/stream_out_buffer_if.sv | 28 ++
 rtl/sob_ram.sv | 29 ++
 rtl/stream_out_buffer.sv | 141 ++++++++++++++
 tb/tb_stream_out_buffer.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sob_pkg.sv
// Shared types and constants for the stream-out buffer.
// States, word/halfword widths and the stream length ceiling.
package sob_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SEND,
    FIN
  } state_t;

  localparam int HALF_W     = 16;
  localparam int WORD_W     = 32;
  localparam int MAX_HALVES = 512;

endpackage

// File: rtl/stream_out_buffer_if.sv
// Halfword stream bus toward the SDRAM write path.
// Master drives valid/address/data, slave drives ready.
interface stream_out_buffer_if
  import sob_pkg::*;
#(
  parameter int WORDS_W = 8
);

  logic              MEM_VALID;
  logic              MEM_READY;
  logic [WORDS_W:0]  MEM_ADDR;
  logic [HALF_W-1:0] MEM_RD;

  modport master (
    output MEM_VALID,
    output MEM_ADDR,
    output MEM_RD,
    input  MEM_READY
  );

  modport slave (
    input  MEM_VALID,
    input  MEM_ADDR,
    input  MEM_RD,
    output MEM_READY
  );

endinterface

// File: rtl/sob_ram.sv
// Pattern store: one write port, one registered read port.
// A same-address read and write return the old word.
module sob_ram
  import sob_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic              CLK,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [WORD_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [AW-1:0]     i_raddr,
  output logic [WORD_W-1:0] o_rdata
);

  logic [WORD_W-1:0] r_mem [2**AW];

  // console write port
  always_ff @(posedge CLK) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // registered read; non-blocking update keeps old data on collision
  always_ff @(posedge CLK) begin
    if (i_re) o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/stream_out_buffer.sv
// Console-loaded pattern buffer streamed out as halfwords.
// Per word: FETCH, SEND low half, SEND high half.
module stream_out_buffer
  import sob_pkg::*;
#(
  parameter int WORDS_W = 8
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               CON_WE,
  input  logic [WORDS_W-1:0] CON_ADDR,
  input  logic [WORD_W-1:0]  CON_WD,
  input  logic               START,
  input  logic [WORDS_W+1:0] LEN,
  output logic               BUSY,
  output logic               DONE,
  stream_out_buffer_if.master mem
);

  localparam int NMAX = 2**(WORDS_W+1);
  localparam logic [WORDS_W+1:0] NMAX_V = NMAX[WORDS_W+1:0];

  state_t r_state;
  state_t w_next;

  logic [WORDS_W:0]   r_idx;
  logic [WORDS_W+1:0] r_n;
  logic [WORD_W-1:0]  r_word;

  logic               w_re;
  logic [WORDS_W-1:0] w_raddr;
  logic [WORD_W-1:0]  w_rdata;
  logic               w_ld_n;
  logic               w_clr_idx;
  logic               w_inc_idx;
  logic               w_ld_word;
  logic               w_busy;
  logic               w_done;
  logic               w_valid;
  logic [WORDS_W+1:0] w_len_eff;
  logic [WORDS_W:0]   w_idx_inc;
  logic               w_last;

  assign w_len_eff = (LEN > NMAX_V) ? NMAX_V : LEN;
  assign w_idx_inc = r_idx + 1'b1;
  assign w_last    = ({1'b0, r_idx} == (r_n - 1'b1));

  sob_ram #(
    .AW (WORDS_W)
  ) u_ram (
    .CLK     (CLK),
    .i_we    (CON_WE),
    .i_waddr (CON_ADDR),
    .i_wdata (CON_WD),
    .i_re    (w_re),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  // state register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // index, latched length and current word
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_idx  <= '0;
      r_n    <= '0;
      r_word <= '0;
    end else begin
      if (w_ld_n)    r_n    <= w_len_eff;
      if (w_clr_idx) r_idx  <= '0;
      if (w_inc_idx) r_idx  <= w_idx_inc;
      if (w_ld_word) r_word <= w_rdata;
    end
  end

  // next state, RAM read requests and status outputs
  always_comb begin
    w_next    = r_state;
    w_re      = 1'b0;
    w_raddr   = '0;
    w_ld_n    = 1'b0;
    w_clr_idx = 1'b0;
    w_inc_idx = 1'b0;
    w_ld_word = 1'b0;
    w_busy    = 1'b0;
    w_done    = 1'b0;
    w_valid   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (START) begin
          w_ld_n = 1'b1;
          if (w_len_eff != '0) begin
            w_clr_idx = 1'b1;
            w_re      = 1'b1;
            w_next    = FETCH;
          end else begin
            w_next = FIN;
          end
        end
      end
      FETCH: begin
        w_busy    = 1'b1;
        w_ld_word = 1'b1;
        w_next    = SEND;
      end
      SEND: begin
        w_busy  = 1'b1;
        w_valid = 1'b1;
        if (mem.MEM_READY) begin
          if (w_last) begin
            w_next = FIN;
          end else begin
            w_inc_idx = 1'b1;
            if (r_idx[0]) begin
              w_re    = 1'b1;
              w_raddr = w_idx_inc[WORDS_W:1];
              w_next  = FETCH;
            end
          end
        end
      end
      FIN: begin
        w_done = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign BUSY          = w_busy;
  assign DONE          = w_done;
  assign mem.MEM_VALID = w_valid;
  assign mem.MEM_ADDR  = r_idx;
  assign mem.MEM_RD    = r_idx[0] ? r_word[WORD_W-1:HALF_W]
                                  : r_word[HALF_W-1:0];

endmodule

// File: tb/tb_stream_out_buffer.sv
// Randomized and directed bench for stream_out_buffer.
// A queue of expected halfwords is checked on every negedge.
module tb_stream_out_buffer;
  import sob_pkg::*;

  logic        CLK;
  logic        RESET;
  logic        CON_WE;
  logic [7:0]  CON_ADDR;
  logic [31:0] CON_WD;
  logic        START;
  logic [9:0]  LEN;
  logic        BUSY;
  logic        DONE;

  stream_out_buffer_if #(.WORDS_W(8)) mem_if ();

  stream_out_buffer #(.WORDS_W(8)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .CON_WE   (CON_WE),
    .CON_ADDR (CON_ADDR),
    .CON_WD   (CON_WD),
    .START    (START),
    .LEN      (LEN),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .mem      (mem_if.master)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] addr;
    logic [15:0] data;
  } hw_t;

  hw_t         exp_q[$];
  logic [31:0] shadow [256];
  logic [15:0] acc_data[$];
  int          acc_addr[$];

  int tests, fails, cyc;
  int acc_total, valid_total, busy_total, done_total;
  int start_cyc, fv_cyc, done_cyc, last_acc_cyc;
  bit prev_stall;
  logic [31:0] prev_addr;
  logic [15:0] prev_rd;
  int base, b0, v0, d0, k;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic con_write(input int a, input logic [31:0] d);
    CON_WE   = 1'b1;
    CON_ADDR = a[7:0];
    CON_WD   = d;
    shadow[a] = d;
    @(posedge CLK);
    #1 CON_WE = 1'b0;
  endtask

  task automatic push_exp(input int len);
    int n;
    hw_t h;
    n = (len > 512) ? 512 : len;
    for (int i = 0; i < n; i++) begin
      h.addr = i;
      h.data = (i % 2) ? shadow[i/2][31:16] : shadow[i/2][15:0];
      exp_q.push_back(h);
    end
  endtask

  task automatic push_one(input int a, input logic [15:0] d);
    hw_t h;
    h.addr = a;
    h.data = d;
    exp_q.push_back(h);
  endtask

  task automatic start_run(input int len);
    START = 1'b1;
    LEN   = len[9:0];
    @(posedge CLK);
    #1 START = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rnd);
    int dd;
    int n;
    dd = done_total;
    n  = 0;
    while (done_total == dd && n < budget) begin
      if (rnd) mem_if.MEM_READY = 1'($urandom_range(0, 1));
      @(posedge CLK);
      #1;
      n++;
    end
    chk("done_seen", done_total - dd, 1);
  endtask

  task automatic wait_valid(input int budget);
    int n;
    n = 0;
    while (!mem_if.MEM_VALID && n < budget) begin
      @(posedge CLK);
      #1;
      n++;
    end
    chk("valid_seen", mem_if.MEM_VALID, 1);
  endtask

  task automatic load_random();
    for (int w = 0; w < 256; w++) con_write(w, $urandom);
  endtask

  initial begin
    tests = 0; fails = 0; cyc = 0;
    acc_total = 0; valid_total = 0; busy_total = 0; done_total = 0;
    start_cyc = 0; fv_cyc = -1; done_cyc = 0; last_acc_cyc = 0;
    prev_stall = 0; prev_addr = 0; prev_rd = 0;
    RESET = 1'b1; CON_WE = 1'b0; CON_ADDR = '0; CON_WD = '0;
    START = 1'b0; LEN = '0; mem_if.MEM_READY = 1'b0;
    for (int w = 0; w < 256; w++) shadow[w] = '0;

    fork
      forever begin
        @(negedge CLK);
        cyc++;
        if (RESET) begin
          exp_q.delete();
          prev_stall = 0;
        end else begin
          if (START && !BUSY) start_cyc = cyc;
          if (BUSY) busy_total++;
          if (prev_stall) begin
            chk("hold_valid", mem_if.MEM_VALID, 1);
            chk("hold_addr", mem_if.MEM_ADDR, prev_addr);
            chk("hold_rd", mem_if.MEM_RD, prev_rd);
          end
          if (mem_if.MEM_VALID) begin
            valid_total++;
            if (fv_cyc < start_cyc) fv_cyc = cyc;
            chk("valid_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
              chk("stream_addr", mem_if.MEM_ADDR, exp_q[0].addr);
              chk("stream_data", mem_if.MEM_RD, exp_q[0].data);
            end
            if (mem_if.MEM_READY) begin
              if (exp_q.size() > 0) void'(exp_q.pop_front());
              acc_total++;
              acc_data.push_back(mem_if.MEM_RD);
              acc_addr.push_back(int'(mem_if.MEM_ADDR));
              last_acc_cyc = cyc;
            end
          end
          if (DONE) begin
            chk("done_drained", exp_q.size(), 0);
            chk("done_not_busy", BUSY, 0);
            done_total++;
            done_cyc = cyc;
          end
          prev_stall = mem_if.MEM_VALID && !mem_if.MEM_READY;
          prev_addr  = 32'(mem_if.MEM_ADDR);
          prev_rd    = mem_if.MEM_RD;
        end
      end
    join_none

    #3;
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_valid", mem_if.MEM_VALID, 0);
    chk("rst_addr", mem_if.MEM_ADDR, 0);
    chk("rst_rd", mem_if.MEM_RD, 0);
    @(posedge CLK);
    @(posedge CLK);
    #1 RESET = 1'b0;

    // basic ordering
    con_write(0, 32'hBBBBAAAA);
    con_write(1, 32'hDDDDCCCC);
    mem_if.MEM_READY = 1'b1;
    base = acc_total;
    b0 = busy_total;
    push_exp(4);
    start_run(4);
    wait_done(40, 0);
    chk("basic_count", acc_total - base, 4);
    chk("basic_h0", acc_data[base], 16'hAAAA);
    chk("basic_h1", acc_data[base+1], 16'hBBBB);
    chk("basic_h2", acc_data[base+2], 16'hCCCC);
    chk("basic_h3", acc_data[base+3], 16'hDDDD);
    chk("basic_a3", acc_addr[base+3], 3);
    chk("basic_busy_cycles", busy_total - b0, 6);
    chk("basic_done_lat", done_cyc - last_acc_cyc, 1);
    chk("first_valid_lat", fv_cyc - start_cyc, 2);

    // backpressure
    mem_if.MEM_READY = 1'b0;
    base = acc_total;
    push_exp(3);
    start_run(3);
    wait_valid(10);
    chk("bp_addr0", mem_if.MEM_ADDR, 0);
    mem_if.MEM_READY = 1'b1;
    @(posedge CLK);
    #1 mem_if.MEM_READY = 1'b0;
    repeat (4) begin
      chk("bp_hold_addr", mem_if.MEM_ADDR, 1);
      chk("bp_hold_rd", mem_if.MEM_RD, 16'hBBBB);
      @(posedge CLK);
      #1;
    end
    mem_if.MEM_READY = 1'b1;
    wait_done(20, 0);
    chk("bp_count", acc_total - base, 3);
    chk("bp_last", acc_data[acc_data.size()-1], 16'hCCCC);

    // zero length
    v0 = valid_total;
    start_run(0);
    wait_done(10, 0);
    chk("len0_done_lat", done_cyc - start_cyc, 1);
    chk("len0_no_valid", valid_total - v0, 0);

    // clamp to 512
    load_random();
    base = acc_total;
    push_exp(700);
    start_run(700);
    wait_done(1000, 0);
    chk("clamp_count", acc_total - base, 512);
    chk("clamp_last_addr", acc_addr[acc_addr.size()-1], 511);
    chk("clamp_last_rd", acc_data[acc_data.size()-1], shadow[255][31:16]);

    // START while busy is ignored
    base = acc_total;
    push_exp(4);
    start_run(4);
    wait_valid(10);
    START = 1'b1;
    LEN = 10'd2;
    @(posedge CLK);
    #1 START = 1'b0;
    d0 = done_total;
    wait_done(40, 0);
    repeat (4) @(posedge CLK);
    #1;
    chk("ign_count", acc_total - base, 4);
    chk("ign_single_done", done_total - d0, 1);

    // console writes during streaming
    con_write(0, 32'h22221111);
    con_write(1, 32'h44443333);
    base = acc_total;
    push_one(0, 16'h1111);
    push_one(1, 16'h2222);
    push_one(2, 16'h7777);
    push_one(3, 16'h8888);
    start_run(4);
    wait_valid(10);
    chk("col_addr0", mem_if.MEM_ADDR, 0);
    con_write(1, 32'h88887777);
    con_write(0, 32'h66665555);
    wait_done(40, 0);
    chk("col_h0", acc_data[base], 16'h1111);
    chk("col_h1", acc_data[base+1], 16'h2222);
    chk("col_h2", acc_data[base+2], 16'h7777);
    chk("col_h3", acc_data[base+3], 16'h8888);

    // reset mid-stream
    push_exp(20);
    start_run(20);
    k = 0;
    while (!(mem_if.MEM_VALID && mem_if.MEM_ADDR == 9'd5) && k < 40) begin
      @(posedge CLK);
      #1;
      k++;
    end
    chk("rst_mid_reached", mem_if.MEM_ADDR, 5);
    d0 = done_total;
    RESET = 1'b1;
    #1;
    chk("rst_mid_busy", BUSY, 0);
    chk("rst_mid_valid", mem_if.MEM_VALID, 0);
    chk("rst_mid_done", DONE, 0);
    @(posedge CLK);
    #1 RESET = 1'b0;
    @(posedge CLK);
    #1;
    chk("rst_mid_no_done", done_total - d0, 0);
    base = acc_total;
    push_exp(2);
    start_run(2);
    wait_done(20, 0);
    chk("restart_count", acc_total - base, 2);
    chk("restart_addr0", acc_addr[base], 0);

    // randomized runs
    for (int r = 0; r < 6; r++) begin
      int len;
      load_random();
      len = $urandom_range(1, 512);
      base = acc_total;
      d0 = done_total;
      push_exp(len);
      start_run(len);
      wait_done(4000, 1);
      repeat (3) @(posedge CLK);
      #1;
      chk("rand_count", acc_total - base, len);
      chk("rand_one_done", done_total - d0, 1);
    end

    mem_if.MEM_READY = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("final_queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
